lisp_exec_unit: RTL and testbench

Parametrised execution unit that succeeds the fixed-operand ALU top level. It wraps the ALU with a register file, a command/response handshake and a small control FSM, so that operands come from architectural registers or an immediate instead of constants. Results are written back and reported. It sits between the instruction sequencer (command side) and the writeback/trace logic (response side).

---
 rtl/lisp_exec_unit_pkg.sv | 22 ++
 rtl/lisp_exec_unit_alu.sv | 45 ++++
 rtl/lisp_exec_unit.sv | 158 +++++++++++++++
 tb/tb_lisp_exec_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lisp_exec_unit_pkg.sv
// Shared definitions for the LISP execution unit: ALU widths, opcodes and control-FSM encoding.
// Imported by the ALU sub-module and the top level.
package lisp_exec_unit_pkg;

    localparam int unsigned alu_data_width   = 16;
    localparam int unsigned alu_opcode_width = 4;

    localparam logic [3:0] OpAdd   = 4'd0;
    localparam logic [3:0] OpSub   = 4'd1;
    localparam logic [3:0] OpAnd   = 4'd2;
    localparam logic [3:0] OpOr    = 4'd3;
    localparam logic [3:0] OpXor   = 4'd4;
    localparam logic [3:0] OpPassA = 4'd5;
    localparam logic [3:0] OpPassB = 4'd6;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_e;

endpackage

// File: rtl/lisp_exec_unit_alu.sv
// Combinational ALU: ADD/SUB at DATA_W+1 bits (carry / borrow), logic ops and pass-throughs.
// Undefined opcodes yield a zero result with o_err set.
module lisp_exec_unit_alu
    import lisp_exec_unit_pkg::*;
#(
    parameter int unsigned DATA_W = alu_data_width,
    parameter int unsigned OP_W   = alu_opcode_width
) (
    input  logic [OP_W-1:0]   i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_result,
    output logic              o_carry,
    output logic              o_err
);

    logic [DATA_W:0] w_wide;

    always_comb begin
        w_wide   = '0;
        o_result = '0;
        o_carry  = 1'b0;
        o_err    = 1'b0;
        case (i_op)
            OP_W'(OpAdd): begin
                w_wide   = {1'b0, i_a} + {1'b0, i_b};
                o_result = w_wide[DATA_W-1:0];
                o_carry  = w_wide[DATA_W];
            end
            OP_W'(OpSub): begin
                // Wrap into the extra bit marks a borrow (A < B unsigned).
                w_wide   = {1'b0, i_a} - {1'b0, i_b};
                o_result = w_wide[DATA_W-1:0];
                o_carry  = w_wide[DATA_W];
            end
            OP_W'(OpAnd):   o_result = i_a & i_b;
            OP_W'(OpOr):    o_result = i_a | i_b;
            OP_W'(OpXor):   o_result = i_a ^ i_b;
            OP_W'(OpPassA): o_result = i_a;
            OP_W'(OpPassB): o_result = i_b;
            default:        o_err    = 1'b1;
        endcase
    end

endmodule

// File: rtl/lisp_exec_unit.sv
// Execution unit: register file + ALU behind a command/response handshake.
// One command in flight: IDLE accepts, EXEC computes and writes back, RESP holds the result.
module lisp_exec_unit
    import lisp_exec_unit_pkg::*;
#(
    parameter int unsigned DATA_W = alu_data_width,
    parameter int unsigned NREGS  = 8,
    parameter int unsigned OP_W   = alu_opcode_width,
    parameter int unsigned REG_W  = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [REG_W-1:0]  cmd_dst,
    input  logic [REG_W-1:0]  cmd_src_a,
    input  logic [REG_W-1:0]  cmd_src_b,
    input  logic              cmd_use_imm,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_zero,
    output logic              rsp_carry,
    output logic              rsp_err,
    output logic              busy
);

    state_e              r_state;
    state_e              w_state_next;
    logic                r_out_of_reset;
    logic                w_accept;
    logic                w_exec;

    logic [OP_W-1:0]     r_op;
    logic [REG_W-1:0]    r_dst;
    logic [DATA_W-1:0]   r_opa;
    logic [DATA_W-1:0]   r_opb;

    logic [DATA_W-1:0]   r_regs [NREGS];
    logic [DATA_W-1:0]   w_rd_a;
    logic [DATA_W-1:0]   w_rd_b;

    logic [DATA_W-1:0]   w_alu_result;
    logic                w_alu_carry;
    logic                w_alu_err;

    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_rsp_zero;
    logic                r_rsp_carry;
    logic                r_rsp_err;

    // Held low through reset and raised on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_of_reset <= 1'b0;
        end else begin
            r_out_of_reset <= 1'b1;
        end
    end

    assign cmd_ready = (r_state == StIdle) && r_out_of_reset;
    assign busy      = (r_state != StIdle);
    assign rsp_valid = (r_state == StResp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_exec       = 1'b0;
        case (r_state)
            StIdle: begin
                if (cmd_valid && cmd_ready) begin
                    w_accept     = 1'b1;
                    w_state_next = StExec;
                end
            end
            StExec: begin
                w_exec       = 1'b1;
                w_state_next = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // r0 is hard-wired to zero on the read side.
    assign w_rd_a = (cmd_src_a == '0) ? '0 : r_regs[cmd_src_a];
    assign w_rd_b = (cmd_src_b == '0) ? '0 : r_regs[cmd_src_b];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op  <= '0;
            r_dst <= '0;
            r_opa <= '0;
            r_opb <= '0;
        end else if (w_accept) begin
            r_op  <= cmd_op;
            r_dst <= cmd_dst;
            r_opa <= w_rd_a;
            r_opb <= cmd_use_imm ? cmd_imm : w_rd_b;
        end
    end

    lisp_exec_unit_alu #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W)
    ) u_alu (
        .i_op     (r_op),
        .i_a      (r_opa),
        .i_b      (r_opb),
        .o_result (w_alu_result),
        .o_carry  (w_alu_carry),
        .o_err    (w_alu_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_exec && !w_alu_err && (r_dst != '0)) begin
            r_regs[r_dst] <= w_alu_result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_data  <= '0;
            r_rsp_zero  <= 1'b0;
            r_rsp_carry <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else if (w_exec) begin
            r_rsp_data  <= w_alu_result;
            r_rsp_zero  <= (w_alu_result == '0);
            r_rsp_carry <= w_alu_carry;
            r_rsp_err   <= w_alu_err;
        end
    end

    assign rsp_data  = r_rsp_data;
    assign rsp_zero  = r_rsp_zero;
    assign rsp_carry = r_rsp_carry;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_lisp_exec_unit.sv
// Self-checking bench for lisp_exec_unit: directed vector table, hand-written corner sequences
// and randomized commands checked against an arithmetic register-file model.
module tb_lisp_exec_unit;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [2:0]  cmd_dst;
    logic [2:0]  cmd_src_a;
    logic [2:0]  cmd_src_b;
    logic        cmd_use_imm;
    logic [15:0] cmd_imm;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_zero;
    logic        rsp_carry;
    logic        rsp_err;
    logic        busy;

    lisp_exec_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_dst     (cmd_dst),
        .cmd_src_a   (cmd_src_a),
        .cmd_src_b   (cmd_src_b),
        .cmd_use_imm (cmd_use_imm),
        .cmd_imm     (cmd_imm),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_zero    (rsp_zero),
        .rsp_carry   (rsp_carry),
        .rsp_err     (rsp_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;
    int m_regs [8];

    typedef struct {
        int op;
        int dst;
        int sa;
        int sb;
        bit ui;
        int imm;
        int d;
        bit z;
        bit c;
        bit e;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rd(input int idx);
        return (idx == 0) ? 0 : m_regs[idx];
    endfunction

    // Reference ALU in plain integer arithmetic; returns {err, carry, data[15:0]}.
    function automatic logic [17:0] ref_alu(input int op, input int a, input int b);
        int  d;
        bit  c;
        bit  e;
        d = 0;
        c = 0;
        e = 0;
        case (op)
            0: begin d = (a + b) % 65536; c = (a + b) >= 65536; end
            1: begin d = (a - b + 65536) % 65536; c = a < b; end
            2: d = a & b;
            3: d = a | b;
            4: d = a ^ b;
            5: d = a;
            6: d = b;
            default: e = 1;
        endcase
        return {e, c, 16'(d)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 0;
    endtask

    // Present one command and return just after its accepting edge.
    task automatic issue(input int op, input int dst, input int sa, input int sb,
                         input bit ui, input int imm);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!cmd_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_timeout: cmd_ready got 0 expected 1 at %0t", $time);
        end
        cmd_valid   = 1'b1;
        cmd_op      = 4'(op);
        cmd_dst     = 3'(dst);
        cmd_src_a   = 3'(sa);
        cmd_src_b   = 3'(sb);
        cmd_use_imm = ui;
        cmd_imm     = 16'(imm);
        @(posedge clk);
        #1;
        cmd_valid   = 1'b0;
        cmd_op      = 4'($urandom);
        cmd_dst     = 3'($urandom);
        cmd_src_a   = 3'($urandom);
        cmd_src_b   = 3'($urandom);
        cmd_use_imm = 1'($urandom);
        cmd_imm     = 16'($urandom);
    endtask

    // Observe the response: fixed 2-cycle latency, optional stall with stability checks.
    task automatic get_rsp(input int stall, output int od, output bit oz, output bit oc,
                           output bit oe);
        rsp_ready = (stall == 0);
        @(negedge clk);
        check("lat_exec_valid", rsp_valid, 0);
        check("lat_exec_busy", busy, 1);
        @(negedge clk);
        check("lat_resp_valid", rsp_valid, 1);
        od = rsp_data;
        oz = rsp_zero;
        oc = rsp_carry;
        oe = rsp_err;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_valid", rsp_valid, 1);
            check("stall_data", rsp_data, od);
            check("stall_cmd_ready", cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_valid", rsp_valid, 0);
    endtask

    task automatic xact(input int op, input int dst, input int sa, input int sb, input bit ui,
                        input int imm, input int stall, output int od, output bit oz,
                        output bit oc, output bit oe);
        logic [17:0] r;
        int          b;
        b = ui ? imm : rd(sb);
        r = ref_alu(op, rd(sa), b);
        issue(op, dst, sa, sb, ui, imm);
        get_rsp(stall, od, oz, oc, oe);
        check("model_data", od, 32'(r[15:0]));
        check("model_zero", oz, (r[15:0] == 16'h0));
        check("model_carry", oc, r[16]);
        check("model_err", oe, r[17]);
        if (!r[17] && dst != 0) m_regs[dst] = int'(r[15:0]);
    endtask

    initial begin
        int d;
        bit z, c, e;
        n_tests = 0;
        n_fail  = 0;
        model_reset();

        vecs[0]  = '{0, 1, 0, 0, 1, 5,       5,       0, 0, 0};
        vecs[1]  = '{0, 2, 1, 0, 1, 7,       12,      0, 0, 0};
        vecs[2]  = '{6, 3, 0, 0, 1, 'hFFFF,  'hFFFF,  0, 0, 0};
        vecs[3]  = '{0, 4, 3, 0, 1, 1,       0,       1, 1, 0};
        vecs[4]  = '{1, 5, 0, 0, 1, 1,       'hFFFF,  0, 1, 0};
        vecs[5]  = '{6, 0, 0, 0, 1, 'h1234,  'h1234,  0, 0, 0};
        vecs[6]  = '{5, 6, 0, 0, 0, 0,       0,       1, 0, 0};
        vecs[7]  = '{15, 1, 2, 0, 1, 3,      0,       1, 0, 1};
        vecs[8]  = '{5, 7, 1, 0, 0, 0,       5,       0, 0, 0};
        vecs[9]  = '{2, 6, 2, 3, 0, 0,       'hC,     0, 0, 0};
        vecs[10] = '{3, 7, 1, 2, 0, 0,       'hD,     0, 0, 0};
        vecs[11] = '{1, 6, 1, 2, 0, 0,       'hFFF9,  0, 1, 0};
        vecs[12] = '{0, 1, 1, 1, 0, 0,       'hA,     0, 0, 0};
        vecs[13] = '{5, 2, 1, 0, 0, 0,       'hA,     0, 0, 0};
        vecs[14] = '{6, 3, 0, 5, 0, 0,       'hFFFF,  0, 0, 0};
        vecs[15] = '{7, 2, 1, 0, 1, 0,       0,       1, 0, 1};
        vecs[16] = '{5, 4, 2, 0, 0, 0,       'hA,     0, 0, 0};

        rst_n       = 1'b0;
        rsp_ready   = 1'b1;
        cmd_valid   = 1'b0;
        cmd_op      = '0;
        cmd_dst     = '0;
        cmd_src_a   = '0;
        cmd_src_b   = '0;
        cmd_use_imm = 1'b0;
        cmd_imm     = '0;
        #1;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_cmd_ready", cmd_ready, 1);

        foreach (vecs[i]) begin
            xact(vecs[i].op, vecs[i].dst, vecs[i].sa, vecs[i].sb, vecs[i].ui, vecs[i].imm, 0,
                 d, z, c, e);
            check($sformatf("vec%0d_data", i), d, vecs[i].d);
            check($sformatf("vec%0d_zero", i), z, vecs[i].z);
            check($sformatf("vec%0d_carry", i), c, vecs[i].c);
            check($sformatf("vec%0d_err", i), e, vecs[i].e);
        end

        // Backpressure: XOR result held for 10 stalled cycles.
        xact(6, 1, 0, 0, 1, 'h00FF, 0, d, z, c, e);
        xact(6, 2, 0, 0, 1, 'h0F0F, 0, d, z, c, e);
        xact(4, 3, 1, 2, 0, 0, 10, d, z, c, e);
        check("bp_xor_data", d, 'h0FF0);
        xact(5, 4, 3, 0, 0, 0, 0, d, z, c, e);
        check("bp_readback", d, 'h0FF0);

        // Reset during EXEC drops the write.
        issue(6, 5, 0, 0, 1, 'hABCD);
        check("mid_exec_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("arst_rsp_valid", rsp_valid, 0);
        check("arst_rsp_data", rsp_data, 0);
        check("arst_flags", {rsp_zero, rsp_carry, rsp_err}, 0);
        check("arst_busy", busy, 0);
        check("arst_cmd_ready", cmd_ready, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("arst_release_ready", cmd_ready, 1);
        xact(5, 6, 5, 0, 0, 0, 0, d, z, c, e);
        check("arst_dst_cleared", d, 0);

        for (int n = 0; n < 60; n++) begin
            int sel;
            int op;
            int stall;
            sel   = int'($urandom_range(0, 8));
            op    = (sel < 8) ? sel : 15;
            stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            xact(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 7)), 1'($urandom), int'($urandom_range(0, 65535)),
                 stall, d, z, c, e);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
